// File: rtl/mdu_dispatch_pkg.sv
// Shared definitions for the MDU dispatch stage: RV32M funct3 codes, the
// dispatch FSM state encoding, and small decode/select helpers.
package mdu_dispatch_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_e;

  function automatic logic is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

  function automatic logic is_unsigned_div(input logic [2:0] funct3);
    return funct3[0];
  endfunction

  // Pick the 32-bit writeback word for an M-op from the full MDU results.
  function automatic logic [31:0] sel_result(input logic [2:0]  funct3,
                                             input logic [63:0] product,
                                             input logic [31:0] quotient,
                                             input logic [31:0] remainder);
    if (!is_div(funct3)) begin
      return (funct3 == F3_MUL) ? product[31:0] : product[63:32];
    end
    return funct3[1] ? remainder : quotient;
  endfunction

endpackage

// File: rtl/mdu_result_cache.sv
// One-entry operand/result cache for the MDU dispatch stage.
// Holds the operands, class and funct3 of the last completed MDU run together
// with its full 64-bit product, quotient and remainder, and reports whether a
// new request can be answered from it.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en_i           capture a completed run (wr_* fields)
//   inv_i             drop the entry (takes priority over wr_en_i)
//   lk_*_i            operands/funct3 of the request being looked up
//   hit_o             request can be served from the entry
//   hit_data_o        selected 32-bit word for the looked-up funct3
module mdu_result_cache
  import mdu_dispatch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en_i,
  input  logic        inv_i,
  input  logic [2:0]  wr_funct3_i,
  input  logic [31:0] wr_rs1_i,
  input  logic [31:0] wr_rs2_i,
  input  logic [63:0] wr_product_i,
  input  logic [31:0] wr_quotient_i,
  input  logic [31:0] wr_remainder_i,
  input  logic [2:0]  lk_funct3_i,
  input  logic [31:0] lk_rs1_i,
  input  logic [31:0] lk_rs2_i,
  output logic        hit_o,
  output logic [31:0] hit_data_o
);

  logic        valid_q;
  logic        div_q;
  logic [2:0]  funct3_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [63:0] product_q;
  logic [31:0] quotient_q;
  logic [31:0] remainder_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      div_q       <= 1'b0;
      funct3_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      product_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else if (inv_i) begin
      valid_q <= 1'b0;
    end else if (wr_en_i) begin
      valid_q     <= 1'b1;
      div_q       <= is_div(wr_funct3_i);
      funct3_q    <= wr_funct3_i;
      rs1_q       <= wr_rs1_i;
      rs2_q       <= wr_rs2_i;
      product_q   <= wr_product_i;
      quotient_q  <= wr_quotient_i;
      remainder_q <= wr_remainder_i;
    end
  end

  logic class_ok;

  always_comb begin
    class_ok = 1'b0;
    if (is_div(lk_funct3_i)) begin
      // DIV/REM share a run; DIVU/REMU share a run.
      class_ok = div_q && (is_unsigned_div(lk_funct3_i) == funct3_q[0]);
    end else begin
      // Low product bits do not depend on operand signedness, so MUL hits any
      // mul-class entry; the high-half ops need the exact same funct3.
      class_ok = !div_q && ((lk_funct3_i == F3_MUL) || (lk_funct3_i == funct3_q));
    end
  end

  assign hit_o      = valid_q && (lk_rs1_i == rs1_q) && (lk_rs2_i == rs2_q) && class_ok;
  assign hit_data_o = sel_result(lk_funct3_i, product_q, quotient_q, remainder_q);

endmodule

// File: rtl/mdu_dispatch.sv
// Sequencing stage in front of the multiply/divide unit. Accepts one RV32M op
// at a time, launches it with a start/done/ack handshake, returns the selected
// 32-bit result with its rd tag, and short-circuits repeated operand pairs
// (MULH+MUL, DIV+REM idioms) through a one-entry result cache.
// Ports:
//   req_*    request from execute (valid/ready, funct3, rs1, rs2, rd)
//   flush    kills the in-flight op; highest priority event
//   resp_*   registered result to writeback (valid/ready, data, rd)
//   mdu_*    launch/ack pulses and registered operands to the MDU, plus its
//            busy/done status and raw results
module mdu_dispatch
  import mdu_dispatch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        mdu_start,
  output logic        mdu_ack,
  output logic [2:0]  mdu_funct3,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  input  logic        mdu_busy,
  input  logic        mdu_done,
  input  logic [63:0] mdu_product,
  input  logic [31:0] mdu_quotient,
  input  logic [31:0] mdu_remainder
);

  state_e      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;

  logic        cache_wr;
  logic        cache_inv;
  logic        cache_hit;
  logic [31:0] cache_data;

  mdu_result_cache u_cache (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en_i        (cache_wr),
    .inv_i          (cache_inv),
    .wr_funct3_i    (funct3_q),
    .wr_rs1_i       (a_q),
    .wr_rs2_i       (b_q),
    .wr_product_i   (mdu_product),
    .wr_quotient_i  (mdu_quotient),
    .wr_remainder_i (mdu_remainder),
    .lk_funct3_i    (req_funct3),
    .lk_rs1_i       (req_rs1),
    .lk_rs2_i       (req_rs2),
    .hit_o          (cache_hit),
    .hit_data_o     (cache_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      funct3_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    data_d    = data_q;
    mdu_start = 1'b0;
    mdu_ack   = 1'b0;
    cache_wr  = 1'b0;
    cache_inv = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          funct3_d = req_funct3;
          a_d      = req_rs1;
          b_d      = req_rs2;
          rd_d     = req_rd;
          if (cache_hit) begin
            data_d  = cache_data;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (!mdu_busy) begin
          mdu_start = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        // A flush coinciding with done is drained rather than completed, so
        // the ack is left to DRAIN where done is still held.
        if (flush) begin
          state_d = S_DRAIN;
        end else if (mdu_done) begin
          mdu_ack  = 1'b1;
          cache_wr = 1'b1;
          data_d   = sel_result(funct3_q, mdu_product, mdu_quotient, mdu_remainder);
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (flush || resp_ready) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        cache_inv = 1'b1;
        if (mdu_done) begin
          mdu_ack = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = data_q;
  assign resp_rd    = rd_q;
  assign mdu_funct3 = funct3_q;
  assign mdu_a      = a_q;
  assign mdu_b      = b_q;

endmodule

// File: tb/tb_mdu_dispatch.sv
module tb_mdu_dispatch;
  import mdu_dispatch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic [4:0]  req_rd = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        mdu_start;
  logic        mdu_ack;
  logic [2:0]  mdu_funct3;
  logic [31:0] mdu_a;
  logic [31:0] mdu_b;
  logic        mdu_busy;
  logic        mdu_done;
  logic [63:0] mdu_product;
  logic [31:0] mdu_quotient;
  logic [31:0] mdu_remainder;

  always #5 clk = ~clk;

  mdu_dispatch dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .mdu_start(mdu_start), .mdu_ack(mdu_ack),
    .mdu_funct3(mdu_funct3), .mdu_a(mdu_a), .mdu_b(mdu_b),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done), .mdu_product(mdu_product),
    .mdu_quotient(mdu_quotient), .mdu_remainder(mdu_remainder)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- RV32M arithmetic reference ----------------
  function automatic logic [63:0] ref_prod(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    case (f3)
      F3_MULHSU: return sa * ub;
      F3_MULHU:  return ua * ub;
      default:   return sa * sb;
    endcase
  endfunction

  function automatic logic [63:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 0) return {32'hFFFF_FFFF, a};
    if (f3[0]) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, 32'h0};
    sa = a; sb = b; q = sa / sb; r = sa % sb;
    return {q, r};
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p, d;
    p = ref_prod(f3, a, b);
    d = ref_div(f3, a, b);
    case (f3)
      F3_MUL:                      return p[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: return p[63:32];
      F3_DIV, F3_DIVU:             return d[63:32];
      default:                     return d[31:0];
    endcase
  endfunction

  // ---------------- MDU behavioural model ----------------
  int          mdu_lat = 3;
  int          m_cnt;
  logic [2:0]  m_f3;
  logic [31:0] m_a, m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_busy <= 1'b0; mdu_done <= 1'b0; m_cnt <= 0;
      m_f3 <= '0; m_a <= '0; m_b <= '0;
      mdu_product <= '0; mdu_quotient <= '0; mdu_remainder <= '0;
    end else begin
      if (mdu_start) begin
        mdu_busy <= 1'b1; m_cnt <= mdu_lat;
        m_f3 <= mdu_funct3; m_a <= mdu_a; m_b <= mdu_b;
      end else if (mdu_busy && !mdu_done) begin
        if (m_cnt <= 1) begin
          mdu_done <= 1'b1;
          mdu_product <= ref_prod(m_f3, m_a, m_b);
          {mdu_quotient, mdu_remainder} <= ref_div(m_f3, m_a, m_b);
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      if (mdu_ack) begin
        mdu_done <= 1'b0; mdu_busy <= 1'b0;
      end
    end
  end

  int n_start = 0;
  int n_ack = 0;
  always @(negedge clk) begin
    if (mdu_start) n_start++;
    if (mdu_ack) n_ack++;
  end

  // ---------------- result cache model + expected responses ----------------
  bit          mc_valid = 0;
  logic [2:0]  mc_f3;
  logic [31:0] mc_a, mc_b;

  function automatic bit model_hit(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!mc_valid || a != mc_a || b != mc_b) return 0;
    if (f3[2] != mc_f3[2]) return 0;
    if (f3[2]) return f3[0] == mc_f3[0];
    return (f3 == F3_MUL) || (f3 == mc_f3);
  endfunction

  typedef struct packed { logic [31:0] data; logic [4:0] rd; } exp_t;
  exp_t expq[$];

  // Compare process: every cycle a response is presented it must match the
  // oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (expq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_resp: got resp_valid=1 data=0x%0h, required no response", resp_data);
      end else begin
        chk("resp_data", resp_data, expq[0].data);
        chk("resp_rd", resp_rd, expq[0].rd);
        chk("req_ready_in_resp", req_ready, 0);
        if (resp_ready) void'(expq.pop_front());
      end
    end
  end

  // Drives one op from IDLE (called at posedge+1) and returns at posedge+1 in IDLE.
  task automatic do_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] lit,
                       input int stall);
    bit hit, got, prev_ack;
    int s0, a0;
    logic [31:0] held;
    exp_t e;
    hit = model_hit(f3, a, b);
    e.data = ref_result(f3, a, b);
    e.rd = rd;
    expq.push_back(e);
    s0 = n_start; a0 = n_ack;
    if (stall > 0) resp_ready = 1'b0;
    req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_rd = rd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    if (hit) chk({nm, "_hit_latency"}, resp_valid, 1);
    else     chk({nm, "_start_latency"}, mdu_start, 1);
    got = 0; prev_ack = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (resp_valid) got = 1;
      else begin prev_ack = mdu_ack; @(negedge clk); end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got no resp_valid in 60 cycles, required a response", nm);
      void'(expq.pop_front());
    end else begin
      chk({nm, "_literal"}, resp_data, lit);
      if (!hit) chk({nm, "_ack_to_resp"}, prev_ack, 1);
      held = resp_data;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk({nm, "_stall_valid"}, resp_valid, 1);
        chk({nm, "_stall_data"}, resp_data, held);
        chk({nm, "_stall_ready"}, req_ready, 0);
      end
      if (stall > 0) begin
        @(posedge clk); #1 resp_ready = 1'b1;
        @(negedge clk);
      end
    end
    @(posedge clk); #1;
    chk({nm, "_starts"}, n_start - s0, hit ? 0 : 1);
    chk({nm, "_acks"}, n_ack - a0, hit ? 0 : 1);
    if (!hit) begin
      mc_valid = 1; mc_f3 = f3; mc_a = a; mc_b = b;
    end
  endtask

  task automatic do_flush_wait(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int s0, a0;
    s0 = n_start; a0 = n_ack;
    mdu_lat = 5;
    req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_rd = 5'd9;
    @(posedge clk); #1 req_valid = 1'b0;   // ISSUE
    @(posedge clk); #1 flush = 1'b1;       // WAIT
    @(posedge clk); #1 flush = 1'b0;       // DRAIN
    repeat (10) @(negedge clk);
    chk("flush_wait_starts", n_start - s0, 1);
    chk("flush_wait_acks", n_ack - a0, 1);
    chk("flush_wait_idle", req_ready, 1);
    mc_valid = 0;
    mdu_lat = 3;
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mdu_start", mdu_start, 0);
    chk("rst_mdu_ack", mdu_ack, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_mdu_a", mdu_a, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("mul_7x6",   F3_MUL,  32'd7, 32'd6, 5'd1, 32'd42, 0);
    do_op("mulh",      F3_MULH, 32'h8000_0000, 32'd2, 5'd2, 32'hFFFF_FFFF, 0);
    do_op("mul_hit",   F3_MUL,  32'h8000_0000, 32'd2, 5'd3, 32'h0, 0);
    do_op("divu",      F3_DIVU, 32'd100, 32'd7, 5'd4, 32'd14, 0);
    do_op("remu_hit",  F3_REMU, 32'd100, 32'd7, 5'd5, 32'd2, 0);
    do_op("rem_miss",  F3_REM,  32'd100, 32'd7, 5'd6, 32'd2, 0);
    do_op("div_by0",   F3_DIV,  32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 0);
    do_op("rem_by0",   F3_REM,  32'd5, 32'd0, 5'd8, 32'd5, 0);

    do_op("mul_3x5",   F3_MUL,  32'd3, 32'd5, 5'd10, 32'd15, 0);
    do_flush_wait(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mul_after_flush", F3_MUL, 32'd3, 32'd5, 5'd11, 32'd15, 0);

    do_op("divu_stall", F3_DIVU, 32'd1000, 32'd10, 5'd12, 32'd100, 4);

    // flush in IDLE: the offered request is ignored
    req_valid = 1'b1; flush = 1'b1; req_funct3 = F3_MUL; req_rs1 = 32'd1; req_rs2 = 32'd1;
    @(posedge clk); #1 req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_ready", req_ready, 1);
    chk("flush_idle_nostart", mdu_start, 0);
    @(posedge clk); #1;

    // flush in ISSUE: no launch pulse
    req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("flush_issue_nostart", mdu_start, 0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_issue_idle", req_ready, 1);
    @(posedge clk); #1;

    do_op("div_ovf",   F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 0);
    do_op("rem_ovf",   F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0, 0);
    do_op("mulhsu",    F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd15, 32'hFFFF_FFFF, 0);
    do_op("mul_hsuhit", F3_MUL,  32'hFFFF_FFFF, 32'd2, 5'd16, 32'hFFFF_FFFE, 0);
    do_op("mulhu_miss", F3_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd17, 32'd1, 0);

    // reset asserted while waiting on the MDU
    mdu_lat = 6;
    req_valid = 1'b1; req_funct3 = F3_DIV; req_rs1 = 32'd9; req_rs2 = 32'd3; req_rd = 5'd18;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("rstw_req_ready", req_ready, 1);
    chk("rstw_resp_valid", resp_valid, 0);
    chk("rstw_mdu_start", mdu_start, 0);
    chk("rstw_mdu_ack", mdu_ack, 0);
    chk("rstw_resp_data", resp_data, 0);
    chk("rstw_resp_rd", resp_rd, 0);
    chk("rstw_mdu_a", mdu_a, 0);
    chk("rstw_mdu_b", mdu_b, 0);
    chk("rstw_mdu_funct3", mdu_funct3, 0);
    mc_valid = 0;
    mdu_lat = 3;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("div_after_rst", F3_DIV, 32'd9, 32'd3, 5'd19, 32'd3, 0);

    chk("expq_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
